// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier (signed N x N -> 2N). Every add/subtract
// step goes through one shared external (N+1)-bit adder-subtractor.
module booth_mult_seq #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product,
    output logic [N:0]     as_a,
    output logic [N:0]     as_b,
    output logic           as_m,
    input  logic [N+1:0]   as_y
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [N:0]       r_a, r_mx;
    logic [N-1:0]     r_q;
    logic             r_q1;
    logic [CW-1:0]    r_cnt;
    logic [2*N-1:0]   r_product;

    logic [N:0]       w_s, w_a_nxt;
    logic [N-1:0]     w_q_nxt;
    logic             w_last;
    logic             w_unused;

    // The carry/borrow bit from the adder-subtractor has no meaning here.
    assign w_unused = as_y[N+1];
    assign w_s      = as_y[N:0];
    assign w_a_nxt  = {w_s[N], w_s[N:1]};
    assign w_q_nxt  = {w_s[0], r_q[N-1:1]};
    assign w_last   = (r_cnt == CW'(1));
    assign product  = r_product;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        ready       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        as_a        = '0;
        as_b        = '0;
        as_m        = 1'b0;
        case (r_state)
            IDLE: begin
                ready = 1'b1;
                if (start) w_state_nxt = CALC;
            end
            CALC: begin
                busy = 1'b1;
                as_a = r_a;
                case ({r_q[0], r_q1})
                    2'b01:   as_b = r_mx;
                    2'b10: begin
                        as_b = r_mx;
                        as_m = 1'b1;
                    end
                    default: ;
                endcase
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Product is captured from the final shifted value so it is valid in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_q       <= '0;
            r_q1      <= 1'b0;
            r_mx      <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a   <= '0;
                        r_q   <= multiplier;
                        r_q1  <= 1'b0;
                        r_mx  <= {multiplicand[N-1], multiplicand};
                        r_cnt <= CW'(N);
                    end
                end
                CALC: begin
                    r_a   <= w_a_nxt;
                    r_q   <= w_q_nxt;
                    r_q1  <= r_q[0];
                    r_cnt <= r_cnt - CW'(1);
                    if (w_last) r_product <= {w_a_nxt[N-1:0], w_q_nxt};
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: directed vector table, corner sequences, and
// random operands compared against plain signed multiplication.
module tb_booth_mult_seq;
    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   multiplicand, multiplier;
    logic           ready, busy, done;
    logic [2*N-1:0] product;
    logic [N:0]     as_a, as_b;
    logic           as_m;
    logic [N+1:0]   as_y;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [N-1:0]   m;
        logic [N-1:0]   q;
        logic [2*N-1:0] p;
    } vec_t;

    booth_mult_seq #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .ready(ready), .busy(busy), .done(done), .product(product),
        .as_a(as_a), .as_b(as_b), .as_m(as_m), .as_y(as_y)
    );

    // External adder-subtractor the controller drives.
    assign as_y = as_m ? ({1'b0, as_a} - {1'b0, as_b}) : ({1'b0, as_a} + {1'b0, as_b});

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [2*N-1:0] model(input logic [N-1:0] m, input logic [N-1:0] q);
        logic signed [N-1:0] ms, qs;
        int e;
        ms = m;
        qs = q;
        e  = int'(ms) * int'(qs);
        return e[2*N-1:0];
    endfunction

    // Called at a negedge while IDLE; returns at a negedge back in IDLE.
    task automatic op(input logic [N-1:0] m, input logic [N-1:0] q, input string nm,
                      output logic [2*N-1:0] p);
        int nb, nd, dc;
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({nm, " ready drop"}, 32'(ready), 32'd0);
        nb = 0; nd = 0; dc = 0; p = '0;
        for (int c = 1; c <= N + 3; c++) begin
            if (busy) nb++;
            if (done) begin
                nd++;
                dc = c;
                p  = product;
            end
            @(negedge clk);
        end
        chk({nm, " busy cycles"}, 32'(nb), 32'(N));
        chk({nm, " done pulses"}, 32'(nd), 32'd1);
        chk({nm, " done cycle"}, 32'(dc), 32'(N + 1));
    endtask

    initial begin
        vec_t tbl[6];
        logic [2*N-1:0] p, last_p;
        logic [N-1:0] rm, rq;
        int nd, err;
        int dones[$];

        tbl[0] = '{m: 8'd3,    q: 8'd5,    p: 16'h000F};
        tbl[1] = '{m: 8'hF9,   q: 8'd6,    p: 16'hFFD6};
        tbl[2] = '{m: 8'd127,  q: 8'h80,   p: 16'hC080};
        tbl[3] = '{m: 8'h80,   q: 8'h80,   p: 16'h4000};
        tbl[4] = '{m: 8'hFF,   q: 8'hFF,   p: 16'h0001};
        tbl[5] = '{m: 8'h80,   q: 8'd127,  p: 16'hC080};

        rst = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset ready", 32'(ready), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset product", 32'(product), 32'd0);
        chk("reset as_a/as_b/as_m", {14'd0, as_a, as_b, as_m}, 32'd0);

        foreach (tbl[i]) begin
            op(tbl[i].m, tbl[i].q, $sformatf("vec%0d", i), p);
            chk($sformatf("vec%0d product", i), 32'(p), 32'(tbl[i].p));
        end

        // Step trace of M=3, Q=5.
        multiplicand = 8'd3; multiplier = 8'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("trace c1 as_m", 32'(as_m), 32'd1);
        chk("trace c1 as_b", 32'(as_b), 32'h003);
        chk("trace c1 as_a", 32'(as_a), 32'h000);
        @(negedge clk);
        chk("trace c2 as_m", 32'(as_m), 32'd0);
        chk("trace c2 as_b", 32'(as_b), 32'h003);
        chk("trace c2 as_a", 32'(as_a), 32'h1FE);
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("trace c5 pair00 as_b", 32'(as_b), 32'h000);
        chk("trace c5 pair00 as_m", 32'(as_m), 32'd0);
        for (int c = 6; c <= N + 2; c++) @(negedge clk);
        chk("trace product", 32'(product), 32'h000F);
        chk("trace back idle", 32'(ready), 32'd1);

        // start pulses during CALC and DONE must be ignored.
        multiplicand = 8'd2; multiplier = 8'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0; multiplicand = 8'd9; multiplier = 8'd9;
        nd = 0;
        for (int c = 1; c <= N + 4; c++) begin
            if (done) begin
                nd++;
                p = product;
            end
            start = (c == 3 || c == N + 1);
            @(negedge clk);
        end
        start = 1'b0;
        chk("ignore start done pulses", 32'(nd), 32'd1);
        chk("ignore start product", 32'(p), 32'h0008);
        chk("ignore start idle", {30'd0, ready, busy}, 32'h2);

        // Reset after the 4th CALC edge abandons the operation.
        multiplicand = 8'd100; multiplier = 8'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 4; c++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset ready", 32'(ready), 32'd1);
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset product", 32'(product), 32'd0);
        nd = 0;
        for (int c = 0; c < N + 2; c++) begin
            if (done || !ready) nd++;
            @(negedge clk);
        end
        chk("midreset no done", 32'(nd), 32'd0);
        op(8'd2, 8'd4, "after reset", p);
        chk("after reset product", 32'(p), 32'h0008);

        // start held high: re-accepted every N+2 cycles, product stable between.
        multiplicand = 8'hFF; multiplier = 8'hFF; start = 1'b1;
        last_p = product;
        err = 0;
        for (int c = 1; c <= 3 * (N + 2); c++) begin
            @(negedge clk);
            if (done) begin
                dones.push_back(c);
                chk($sformatf("hold product c%0d", c), 32'(product), 32'h0001);
                last_p = product;
            end else if (product !== last_p) begin
                err++;
            end
        end
        start = 1'b0;
        chk("hold stable", 32'(err), 32'd0);
        chk("hold done count", 32'(dones.size()), 32'd3);
        if (dones.size() == 3) begin
            chk("hold first done", 32'(dones[0]), 32'(N + 1));
            chk("hold interval 1", 32'(dones[1] - dones[0]), 32'(N + 2));
            chk("hold interval 2", 32'(dones[2] - dones[1]), 32'(N + 2));
        end
        for (int c = 0; c < N + 3; c++) @(negedge clk);

        // Random operands against signed multiplication.
        for (int i = 0; i < 40; i++) begin
            rm = N'($urandom);
            rq = N'($urandom);
            op(rm, rq, $sformatf("rand%0d", i), p);
            chk($sformatf("rand%0d product m=%0h q=%0h", i, rm, rq), 32'(p), 32'(model(rm, rq)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
Sequential radix-2 Booth controller for signed N×N multiplication. It time-shares one external addersubtractor instance, sized N+1 bits, for all add/subtract steps. On each cycle it drives the instance's a/b/m inputs and captures y. It is the first multi-cycle user of the adder-subtractor datapath and gives a 2N-bit signed product after N iteration cycles.

Parameters:
N, 8, operand width in bits (N >= 2). The attached addersubtractor instance is parameterised to n = N+1.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when ready=1
multiplicand  input  N  signed operand M, captured on accepted start
multiplier  input  N  signed operand Q, captured on accepted start
ready  output  1  high in IDLE; start is accepted this cycle
busy  output  1  high in CALC
done  output  1  one-cycle pulse; product valid
product  output  2N  signed result; held until the next accepted start or rst
as_a  output  N+1  to addersubtractor a (accumulator)
as_b  output  N+1  to addersubtractor b (sign-extended M or 0)
as_m  output  1  to addersubtractor m: 0 = add, 1 = subtract
as_y  input  N+2  from addersubtractor y (combinational)

Behaviour:
- Datapath contract: as_y[N:0] = as_a + as_b (as_m=0) or as_a - as_b (as_m=1), modulo 2^(N+1). as_y[N+1] is ignored.
- States: IDLE, CALC, DONE. Internal registers:
  - A: N+1 bits, signed accumulator
  - Q: N bits
  - q_1: 1 bit
  - Mx: N+1 bits, sign-extended multiplicand
  - cnt: clog2(N+1) bits
- Reset (rst=1 at an edge, priority over everything):
  - state=IDLE; A, Q, q_1, Mx, cnt, product all cleared to 0.
  - Resulting outputs: ready=1, busy=0, done=0, product=0, as_a=0, as_b=0, as_m=0.
  - Reset mid-CALC abandons the operation; no done pulse is produced.
- IDLE:
  - ready=1; as_a, as_b, as_m are driven 0.
  - start=1 at an edge loads A=0, Q=multiplier, q_1=0, Mx=sext(multiplicand), cnt=N, and moves to CALC.
  - start=0 stays in IDLE.
- CALC (busy=1, ready=0):
  - as_a=A every cycle.
  - Booth pair {Q[0], q_1} selects the step:
    - 01: as_b=Mx, as_m=0
    - 10: as_b=Mx, as_m=1
    - 00 or 11: as_b=0, as_m=0
  - Each edge: S=as_y[N:0]; then arithmetic shift right of {S, Q, q_1} gives A=S>>>1 (sign-preserving), Q={S[0], Q[N-1:1]}, q_1=Q[0]; cnt decrements.
  - The edge where cnt==1 performs the last step and moves to DONE.
  - Exactly N CALC cycles. start is ignored.
- DONE:
  - done=1, ready=0, busy=0, as_* driven 0.
  - product={A[N-1:0], Q} is registered on the edge entering DONE, so it is already valid while done=1.
  - Next edge returns to IDLE unconditionally; start is ignored in DONE.
- Latency: start sampled at edge E0 → CALC edges E1..EN → done=1 in the cycle after EN. Initiation interval is N+2 cycles.
  - A back-to-back start presented in the first IDLE cycle after DONE is accepted.
- Width rule: the N+1-bit accumulator absorbs the -2^(N-1) multiplicand case, so every signed input pair, including (-2^(N-1))², gives an exact 2N-bit product. No overflow flag exists.
- product is unchanged through CALC of a subsequent operation; it updates only at the edge entering DONE, or is cleared by rst.

Test Plan (N=8):
1. rst 2 cycles, then start with M=3, Q=5 → ready drops next cycle; busy high exactly 8 cycles; done pulses 1 cycle in cycle 9 after accept; product=0x000F.
2. M=-7, Q=6 → product=0xFFD6 (-42). M=127, Q=-128 → product=0xC080 (-16256). M=-128, Q=-128 → product=0x4000 (16384).
3. Step trace for M=3, Q=5: first CALC cycle pair=10 → as_m=1, as_b=0x003; second cycle pair=01 → as_m=0, as_b=0x003; pair 00 → as_b=0.
4. Start with M=2, Q=4, then pulse start with M=9, Q=9 during CALC and in DONE → ignored; product=0x0008; only one done pulse.
5. Start with M=100, Q=100, assert rst after the 4th CALC edge → next cycle ready=1, busy=0, product=0, no done. Then start with M=2, Q=4 → product=0x0008.
6. Hold start=1 continuously with M=-1, Q=-1 → operations re-accepted every N+2=10 cycles; each done shows product=0x0001; product is stable between done pulses.
